core_run_ctrl: RTL and testbench
================================

# core_run_ctrl

Synthesizable run controller sitting directly upstream of CoreTop: it sequences core reset, the core clock-gate enable and the single-cycle `first_fetch_trigger` pulse, then monitors the decode-stage instruction for the halt opcode (`jal x0,0` = 32'h0000006f). It counts run cycles, enforces a watchdog, drains the pipeline and gates the core clock off, reporting done/timeout. This replaces hand-sequenced stimulus, so the same boot/halt flow runs on FPGA and in simulation.

## Interface
- `RESET_CYCLES`, 10, cycles `core_rstn` held low after start (≥1)
- `SETTLE_CYCLES`, 10, cycles with core clock enabled before fetch trigger (≥1)
- `DRAIN_CYCLES`, 10, cycles core clock stays enabled after halt/timeout (≥1)
- `WATCHDOG_CYCLES`, 5000, run-cycle limit before timeout (≥2)
- `HALT_INSTR`, 32'h0000006f, instruction value that ends the run
- `CYCLE_CNT_W`, 32, width of `cycle_count`
- `clk`  in  1  free-running clock (ungated)
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  level/pulse; sampled in IDLE or DONE to begin a run
- `decode_valid`  in  1  `decode_instr` holds a real instruction this cycle
- `decode_instr`  in  32  decode-stage instruction
- `core_rstn`  out  1  active-low reset to CoreTop, registered
- `cg_clk_en`  out  1  enable to core ClockGate, registered
- `first_fetch_trigger`  out  1  one-cycle pulse to CoreTop, registered
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  run finished (halt or timeout); held until next start
- `timeout`  out  1  run ended by watchdog; held until next start
- `cycle_count`  out  CYCLE_CNT_W  run length, held after run

## Operation
- States: IDLE, RESET, SETTLE, GO, RUN, DRAIN, DONE. One internal down-timer sized `$clog2` of largest of RESET/SETTLE/DRAIN +1.
- IDLE: `core_rstn`=0, `cg_clk_en`=0. `start`=1 -> RESET, timer=RESET_CYCLES-1.
- RESET: `core_rstn`=0, `cg_clk_en`=1 (reset must see clock edges). Timer 0 -> SETTLE, timer=SETTLE_CYCLES-1.
- SETTLE: `core_rstn`=1, `cg_clk_en`=1. Timer 0 -> GO.
- GO: `first_fetch_trigger`=1 exactly this cycle; `cycle_count` loads 1 -> RUN.
- RUN: `cycle_count` +1 per cycle, saturating at all-ones. Halt = `decode_valid && decode_instr==HALT_INSTR` -> DRAIN, `timeout` stays 0. Else if `cycle_count`==WATCHDOG_CYCLES -> DRAIN with `timeout`=1. Halt and watchdog same cycle: halt wins, `timeout`=0. `cycle_count` frozen on leaving RUN.
- DRAIN: `cg_clk_en`=1 for DRAIN_CYCLES, then -> DONE.
- DONE: `cg_clk_en`=0, `core_rstn`=1, `done`=1. `start`=1 -> RESET; clears `done`, `timeout`, `cycle_count` on that transition.
- `start` in any other state ignored. `decode_*` ignored outside RUN.
- Reset values (any time, including mid-run): state IDLE, `core_rstn`=0, `cg_clk_en`=0, `first_fetch_trigger`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0, timer=0.

## Timing
- All outputs registered; change only on `clk` rising edge or `rst` assertion.
- `start` high at edge N (IDLE) -> `core_rstn`=0,`cg_clk_en`=1 from N+1 for exactly RESET_CYCLES cycles.
- `core_rstn` rises at edge N+1+RESET_CYCLES; `first_fetch_trigger` high for the one cycle starting N+1+RESET_CYCLES+SETTLE_CYCLES.
- Halt sampled at edge M in RUN -> DRAIN from M+1; `cg_clk_en` falls and `done` rises at edge M+1+DRAIN_CYCLES.
- `cycle_count` final value = cycles from GO (inclusive) to halt cycle (inclusive).
- Timeout: `cycle_count` reaches WATCHDOG_CYCLES, DRAIN entered next edge; final `cycle_count`=WATCHDOG_CYCLES.
- `busy` deasserts same edge `done` asserts.

## Test plan
- Params RESET=3, SETTLE=2, DRAIN=4, WATCHDOG=20; `start` pulse at cycle 0 -> `core_rstn` low cycles 1-3, trigger high cycle 6 only, `cg_clk_en` high from cycle 1.
- Same setup, halt instr valid at 5th RUN cycle -> `cycle_count`=6, `done`=1 and `cg_clk_en`=0 exactly 4 cycles later, `timeout`=0.
- No halt -> `cycle_count`=20, `timeout`=1, `done`=1 after DRAIN; halt with `decode_valid`=0 ignored.
- Halt on the same cycle `cycle_count`==20 -> `timeout`=0, `cycle_count`=20.
- `start` held high through whole run -> single run (ignored while busy), immediate restart from DONE clears `done`/`timeout`/`cycle_count`.
- Assert `rst` mid-RUN -> same cycle all outputs at reset values, `core_rstn`=0; after release, new `start` gives normal sequence.

Source files
------------

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// Boot/halt sequencer placed in front of CoreTop. A run holds the core in
// reset with its clock enabled, lets it settle, fires a single fetch trigger,
// then counts run cycles until the decode stage shows the halt instruction or
// the watchdog expires. The core clock is then kept on for a drain window and
// finally gated off with done (and timeout, if the watchdog ended the run)
// reported until the next start.
//
// Ports:
//   clk                  free-running (ungated) clock
//   rst                  asynchronous, active-high reset
//   start                begins a run when sampled in IDLE or DONE
//   decode_valid         decode_instr carries a real instruction this cycle
//   decode_instr         decode-stage instruction word
//   core_rstn            active-low reset to CoreTop (registered)
//   cg_clk_en            core clock-gate enable (registered)
//   first_fetch_trigger  one-cycle fetch kick to CoreTop (registered)
//   busy                 run in progress (every state except IDLE/DONE)
//   done                 run finished; held until the next start
//   timeout              run ended by the watchdog; held until the next start
//   cycle_count          run length from GO to the halt cycle, held after run
module core_run_ctrl #(
  parameter int unsigned RESET_CYCLES    = 10,
  parameter int unsigned SETTLE_CYCLES   = 10,
  parameter int unsigned DRAIN_CYCLES    = 10,
  parameter int unsigned WATCHDOG_CYCLES = 5000,
  parameter logic [31:0] HALT_INSTR      = 32'h0000006f,
  parameter int unsigned CYCLE_CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   decode_valid,
  input  logic [31:0]            decode_instr,
  output logic                   core_rstn,
  output logic                   cg_clk_en,
  output logic                   first_fetch_trigger,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CYCLE_CNT_W-1:0] cycle_count
);

  // One shared down-timer covers the reset, settle and drain windows.
  localparam int unsigned MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_MAX = (MAX_RS > DRAIN_CYCLES) ? MAX_RS : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 32'd0) ? $clog2(TMR_MAX + 32'd1) : 1;

  localparam logic [TMR_W-1:0] TMR_RESET_LOAD  = TMR_W'(RESET_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMR_SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMR_DRAIN_LOAD  = TMR_W'(DRAIN_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMR_ZERO        = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE         = TMR_W'(32'd1);

  localparam logic [CYCLE_CNT_W-1:0] CNT_ZERO  = {CYCLE_CNT_W{1'b0}};
  localparam logic [CYCLE_CNT_W-1:0] CNT_ONE   = CYCLE_CNT_W'(32'd1);
  localparam logic [CYCLE_CNT_W-1:0] CNT_MAX   = {CYCLE_CNT_W{1'b1}};
  localparam logic [CYCLE_CNT_W-1:0] CNT_WDOG  = CYCLE_CNT_W'(WATCHDOG_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_GO     = 3'd3,
    ST_RUN    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [TMR_W-1:0]       timer_r;
  logic [TMR_W-1:0]       timer_nxt_s;
  logic [CYCLE_CNT_W-1:0] cnt_nxt_s;
  logic                   timeout_nxt_s;
  logic                   halt_s;
  logic                   wdog_hit_s;
  logic                   rstn_nxt_s;
  logic                   cg_nxt_s;
  logic                   trig_nxt_s;
  logic                   busy_nxt_s;
  logic                   done_nxt_s;

  // Saturating increment so a run longer than the counter range cannot wrap.
  function automatic logic [CYCLE_CNT_W-1:0] sat_inc(input logic [CYCLE_CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  assign halt_s     = decode_valid && (decode_instr == HALT_INSTR);
  assign wdog_hit_s = (cycle_count == CNT_WDOG);

  // Next-state, timer, run counter and timeout flag.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    cnt_nxt_s     = cycle_count;
    timeout_nxt_s = timeout;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // A new run clears the previous run's results on the way into RESET.
        if (start) begin
          state_nxt_s   = ST_RESET;
          timer_nxt_s   = TMR_RESET_LOAD;
          cnt_nxt_s     = CNT_ZERO;
          timeout_nxt_s = 1'b0;
        end else begin
          state_nxt_s   = state_r;
        end
      end
      ST_RESET: begin
        if (timer_r == TMR_ZERO) begin
          state_nxt_s = ST_SETTLE;
          timer_nxt_s = TMR_SETTLE_LOAD;
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
      ST_SETTLE: begin
        // The GO cycle itself is the first counted run cycle.
        if (timer_r == TMR_ZERO) begin
          state_nxt_s = ST_GO;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
      ST_GO: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = sat_inc(cycle_count);
      end
      ST_RUN: begin
        // Halt outranks the watchdog; the count freezes on leaving RUN.
        if (halt_s) begin
          state_nxt_s = ST_DRAIN;
          timer_nxt_s = TMR_DRAIN_LOAD;
        end else if (wdog_hit_s) begin
          state_nxt_s   = ST_DRAIN;
          timer_nxt_s   = TMR_DRAIN_LOAD;
          timeout_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = sat_inc(cycle_count);
        end
      end
      ST_DRAIN: begin
        if (timer_r == TMR_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = TMR_ZERO;
      end
    endcase
  end

  // Output values for the state being entered, so every output is a flop.
  always_comb begin
    rstn_nxt_s = 1'b0;
    cg_nxt_s   = 1'b0;
    trig_nxt_s = 1'b0;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        rstn_nxt_s = 1'b0;
      end
      ST_RESET: begin
        cg_nxt_s   = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_SETTLE, ST_RUN, ST_DRAIN: begin
        rstn_nxt_s = 1'b1;
        cg_nxt_s   = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_GO: begin
        rstn_nxt_s = 1'b1;
        cg_nxt_s   = 1'b1;
        trig_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        rstn_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        rstn_nxt_s = 1'b0;
      end
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      timer_r             <= TMR_ZERO;
      cycle_count         <= CNT_ZERO;
      timeout             <= 1'b0;
      core_rstn           <= 1'b0;
      cg_clk_en           <= 1'b0;
      first_fetch_trigger <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state_r             <= state_nxt_s;
      timer_r             <= timer_nxt_s;
      cycle_count         <= cnt_nxt_s;
      timeout             <= timeout_nxt_s;
      core_rstn           <= rstn_nxt_s;
      cg_clk_en           <= cg_nxt_s;
      first_fetch_trigger <= trig_nxt_s;
      busy                <= busy_nxt_s;
      done                <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl with RESET=3, SETTLE=2, DRAIN=4, WATCHDOG=20.
// A vector table covers the first boot/halt run cycle by cycle; hand-written
// sequences then cover watchdog timeout, halt on the watchdog cycle, start
// held high with immediate restart, and an asynchronous reset mid-run.
module tb_core_run_ctrl;

  localparam logic [31:0] HALT = 32'h0000006f;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decode_valid;
  logic [31:0] decode_instr;
  logic        core_rstn;
  logic        cg_clk_en;
  logic        first_fetch_trigger;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        start;
    logic        dv;
    logic [31:0] instr;
    logic        rstn;
    logic        cg;
    logic        trig;
    logic        busy;
    logic        done;
    logic        to;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[18];

  core_run_ctrl #(
    .RESET_CYCLES(3),
    .SETTLE_CYCLES(2),
    .DRAIN_CYCLES(4),
    .WATCHDOG_CYCLES(20),
    .HALT_INSTR(32'h0000006f),
    .CYCLE_CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .decode_valid(decode_valid),
    .decode_instr(decode_instr),
    .core_rstn(core_rstn),
    .cg_clk_en(cg_clk_en),
    .first_fetch_trigger(first_fetch_trigger),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rstn, input logic e_cg,
                         input logic e_trig, input logic e_busy, input logic e_done,
                         input logic e_to, input logic [31:0] e_cnt);
    chk({tag, ".core_rstn"}, {31'd0, core_rstn}, {31'd0, e_rstn});
    chk({tag, ".cg_clk_en"}, {31'd0, cg_clk_en}, {31'd0, e_cg});
    chk({tag, ".trigger"},   {31'd0, first_fetch_trigger}, {31'd0, e_trig});
    chk({tag, ".busy"},      {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".done"},      {31'd0, done}, {31'd0, e_done});
    chk({tag, ".timeout"},   {31'd0, timeout}, {31'd0, e_to});
    chk({tag, ".count"},     cycle_count, e_cnt);
  endtask

  // Pulses (or holds) start for one cycle and walks to the GO cycle.
  task automatic start_run(input string tag, input logic hold);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    chk_all({tag, ".reset1"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    step();
    chk({tag, ".reset3.core_rstn"}, {31'd0, core_rstn}, 32'd0);
    step();
    chk_all({tag, ".settle1"}, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    step();
    chk_all({tag, ".go"}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    decode_valid = 1'b0;
    decode_instr = NOP;

    // cycle-by-cycle first run: start at cycle 0, halt in the 5th RUN cycle
    //            start dv    instr  rstn  cg    trig  busy  done  to    cnt
    vecs[0]  = '{1'b1, 1'b0, NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, NOP,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, NOP,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, NOP,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b1, 1'b0, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b1, HALT, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
    vecs[7]  = '{1'b0, 1'b0, HALT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[8]  = '{1'b0, 1'b1, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3};
    vecs[9]  = '{1'b1, 1'b0, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4};
    vecs[10] = '{1'b0, 1'b1, 32'h0000106f, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5};
    vecs[11] = '{1'b0, 1'b1, HALT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[12] = '{1'b0, 1'b0, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[13] = '{1'b1, 1'b1, HALT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[14] = '{1'b0, 1'b0, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[15] = '{1'b0, 1'b0, NOP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[16] = '{1'b0, 1'b0, NOP,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6};
    vecs[17] = '{1'b0, 1'b0, NOP,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6};

    step();
    step();
    chk_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 18; i++) begin
      chk_all($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].cg, vecs[i].trig,
              vecs[i].busy, vecs[i].done, vecs[i].to, vecs[i].cnt);
      start        = vecs[i].start;
      decode_valid = vecs[i].dv;
      decode_instr = vecs[i].instr;
      step();
    end

    // watchdog: halt word present but never valid
    decode_valid = 1'b0;
    decode_instr = HALT;
    start_run("wdog", 1'b0);
    for (int i = 0; i < 19; i++) step();
    chk_all("wdog.run19", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd20);
    step();
    chk_all("wdog.drain1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd20);
    step();
    step();
    step();
    chk_all("wdog.drain4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd20);
    step();
    chk_all("wdog.done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd20);

    // halt arrives on the same cycle the watchdog would fire
    start_run("tie", 1'b0);
    for (int i = 0; i < 19; i++) step();
    chk({"tie.run19.count"}, cycle_count, 32'd20);
    decode_valid = 1'b1;
    decode_instr = HALT;
    step();
    decode_valid = 1'b0;
    chk_all("tie.drain1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd20);
    for (int i = 0; i < 4; i++) step();
    chk_all("tie.done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20);

    // start held high for the whole run, then an immediate restart from DONE
    start_run("hold", 1'b1);
    step();
    chk({"hold.run1.count"}, cycle_count, 32'd2);
    decode_valid = 1'b1;
    decode_instr = HALT;
    step();
    decode_valid = 1'b0;
    chk_all("hold.drain1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
    for (int i = 0; i < 4; i++) step();
    chk_all("hold.done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
    step();
    chk_all("hold.restart", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk({"hold.go.trigger"}, {31'd0, first_fetch_trigger}, 32'd1);

    // asynchronous reset in the middle of RUN
    step();
    step();
    chk({"mid.run2.count"}, cycle_count, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid.rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk_all("mid.rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("mid.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    start_run("post", 1'b0);
    step();
    decode_valid = 1'b1;
    decode_instr = HALT;
    step();
    decode_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_all("post.done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
